// File: rtl/blinkled_multi.sv
// blinkled_multi: runtime-configurable LED pattern generator (count / rotate / bounce / hold)
// A prescaler divides CLK into a tick; each tick advances the pattern. New mode/period
// arrive through a valid/ready port and take effect only on a tick boundary.
// Optional macro BLINKLED_PWM_EN adds a DUTY input and an 8-bit PWM brightness mask on LED.
module blinkled_multi #(
    parameter int          WIDTH          = 8,
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned DEFAULT_PERIOD = 1023,
    parameter logic [1:0]  DEFAULT_MODE   = 2'd0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    input  logic [1:0]           CFG_MODE,
    input  logic [CNT_WIDTH-1:0] CFG_PERIOD,
    output logic                 TICK,
`ifdef BLINKLED_PWM_EN
    input  logic [7:0]           DUTY,
`endif
    output logic [WIDTH-1:0]     LED
);
    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;
    localparam logic       DIR_LEFT    = 1'b0;

    logic [CNT_WIDTH-1:0] count, period_r, shadow_period;
    logic [1:0]           mode_r, shadow_mode;
    logic [WIDTH-1:0]     pattern, rot, bnc, adv;
    logic                 dir, pending, tick, at_end, go_left;

    // Value the pattern takes when a mode becomes active; HOLD freezes whatever is showing.
    function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] m, input logic [WIDTH-1:0] cur);
        return (m == MODE_ROTATE || m == MODE_BOUNCE) ? WIDTH'(1) : (m == MODE_COUNT) ? '0 : cur;
    endfunction

    assign tick      = count == period_r;
    assign CFG_READY = !pending;

    // Next pattern for a plain tick; the bounce turns around on the same tick it hits an end.
    always_comb begin
        rot     = (pattern << 1) | (pattern >> (WIDTH - 1));
        at_end  = (dir == DIR_LEFT) ? pattern[WIDTH-1] : pattern[0];
        go_left = (dir == DIR_LEFT) != at_end;
        bnc     = (WIDTH == 1) ? pattern : go_left ? pattern << 1 : pattern >> 1;
        adv     = (mode_r == MODE_COUNT)  ? pattern + WIDTH'(1) :
                  (mode_r == MODE_ROTATE) ? rot :
                  (mode_r == MODE_BOUNCE) ? bnc : pattern;
    end

    // Prescaler, config capture and tick-aligned apply / pattern advance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count         <= '0;
            period_r      <= CNT_WIDTH'(DEFAULT_PERIOD);
            mode_r        <= DEFAULT_MODE;
            pattern       <= init_pattern(DEFAULT_MODE, '0);
            dir           <= DIR_LEFT;
            pending       <= 1'b0;
            shadow_mode   <= DEFAULT_MODE;
            shadow_period <= CNT_WIDTH'(DEFAULT_PERIOD);
            TICK          <= 1'b0;
        end else begin
            TICK  <= tick;
            count <= tick ? '0 : count + CNT_WIDTH'(1);
            if (CFG_VALID && !pending) begin
                shadow_mode   <= CFG_MODE;
                shadow_period <= CFG_PERIOD;
                pending       <= 1'b1;
            end
            if (tick && pending) begin
                mode_r   <= shadow_mode;
                period_r <= shadow_period;
                count    <= '0;
                pattern  <= init_pattern(shadow_mode, pattern);
                dir      <= DIR_LEFT;
                pending  <= 1'b0;
            end else if (tick) begin
                pattern <= adv;
                dir     <= (mode_r == MODE_BOUNCE && at_end) ? ~dir : dir;
            end
        end
    end

`ifdef BLINKLED_PWM_EN
    logic [7:0] pwm_cnt;

    // Free-running PWM phase counter; wraps 255 -> 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + 8'd1;
    end

    // Pattern gated by the brightness window.
    always_comb begin
        LED = pattern & {WIDTH{pwm_cnt < DUTY}};
    end
`else
    // LED mirrors the pattern register directly.
    always_comb begin
        LED = pattern;
    end
`endif
endmodule
